secret_stim_check: RTL
======================

Name: secret_stim_check

Overview:
- Self-contained stimulus generator and response checker for the secret accumulator block shipped as a protected library.
- Drives that block's a/b inputs from an LFSR and captures its x output.
- Compares x each cycle against an internal cycle-accurate model of the accumulate/threshold/secret-offset function, then reports pass/fail.
- Sits beside the protected-library instance in the example top so a release can be sanity-checked without exposing source.

Parameters:
- SECRET, 32'd9: offset added on the below-threshold path of the model.
- THRESH, 32'd10: accumulator threshold; the model takes the b path when accum > THRESH (unsigned).
- A_MASK, 32'h0000_0003: AND mask on generated a values; keeps the accumulator small so both paths are exercised.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- num_vec  input  16  vector count, sampled on start.
- seed  input  32  LFSR seed, sampled on start; 0 is replaced by 1.
- a  output  32  stimulus to the DUT's a input, registered.
- b  output  32  stimulus to the DUT's b input, registered.
- x  input  32  DUT response.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- err_count  output  16  mismatch count, saturating at 16'hFFFF.
- first_err_idx  output  16  index of the first mismatching vector; 16'hFFFF if none.
- pass  output  1  done && err_count==0.

Behaviour:
- Reset values: state=IDLE; a=0, b=0, busy=0, done=0, err_count=0, first_err_idx=16'hFFFF, pass=0; model_acc=0; lfsr=1; cmp_v=0.
- Outside RUN, a and b are driven to 0, so the DUT accumulator holds its value.
- The model tracks the DUT every cycle: model_acc <= model_acc + a on every edge, 32-bit wrap.
- LFSR: 32-bit Galois, taps 32,22,2,1 (mask 32'h8020_0003). It advances once per RUN cycle.
  - a <= lfsr & A_MASK.
  - b <= {lfsr[15:0], lfsr[31:16]}.
- Expected value, per vector k: the model registers exp <= (model_acc > THRESH) ? b : a+b+SECRET, 32-bit wrap. It uses the a/b/model_acc present in the same cycle the DUT samples them.
- Compare: cmp_v and idx are registered alongside exp. In the following cycle, if cmp_v && x!=exp:
  - err_count increments (saturating);
  - first_err_idx is set to idx if it is still 16'hFFFF.
- Latency: vector k on a/b in RUN cycle k; DUT x valid and compared in cycle k+1.
- FSM:
  - IDLE/DONE --start--> RUN. On entry: num_vec latched, lfsr seeded, err_count=0, first_err_idx=16'hFFFF, done=0.
  - IDLE/DONE --start with num_vec==0--> DONE next cycle, with pass=1 and no vectors driven.
  - RUN: drives vector idx (0..num_vec-1) each cycle. After the last vector --> DRAIN.
  - DRAIN: 1 cycle, a=b=0. The final vector is compared here --> DONE.
  - DONE: holds results and done=1 until the next start.
- start while busy: ignored; no counter or state change.
- Reset mid-run: returns to IDLE immediately and clears all results; model_acc returns to 0.
  - The DUT has no reset. Asserting rst after time 0 desynchronises the model unless the DUT is also reinitialised.
  - Subsequent mismatches in that case are correct behaviour, not a checker bug.
- The accumulator wraps silently in both the model and the DUT; no special handling.

Test Plan:
1. A_MASK=0, seed=32'h1, num_vec=8, matching DUT → a=0 throughout, x==b+9 each cycle; done after 10 cycles; err_count=0, pass=1, first_err_idx=16'hFFFF.
2. Checker SECRET=8 vs DUT secret 9, A_MASK=0, num_vec=8 → every compare off by 1; err_count=8, first_err_idx=0, pass=0.
3. A_MASK=3, seed=32'hACE1, num_vec=200, matching DUT → both branches hit (first vectors below threshold, later above); err_count=0, pass=1.
4. num_vec=0, start pulse → a/b stay 0; done=1 on the cycle after start; err_count=0, pass=1.
5. Second start pulse at idx=3 of a num_vec=10 run → ignored; the run ends after 10 vectors and results match a run without the extra pulse.
6. rst asserted at idx=5 of a num_vec=10 run → next cycle: IDLE, busy=0, done=0, err_count=0, first_err_idx=16'hFFFF, a=b=0.

Source files
------------

// File: rtl/secret_stim_check.sv
`default_nettype none
// ============================================================================
// Module      : secret_stim_check
// Description : Stimulus generator and response checker for the protected
//               secret accumulator. An LFSR drives the accumulator's a/b
//               inputs. The registered x response is compared one cycle later
//               against an internal cycle-accurate model of the
//               accumulate / threshold / secret-offset function. Mismatches
//               are counted and the first failing vector index is recorded.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               start              - run request (honoured in IDLE/DONE only)
//               num_vec, seed      - vector count and LFSR seed, taken on start
//               a, b               - registered stimulus to the accumulator
//               x                  - accumulator response
//               busy, done, pass   - run status
//               err_count          - saturating mismatch count
//               first_err_idx      - first failing vector, 16'hFFFF if none
// Revision    : 1.0 - initial release
// ============================================================================
module secret_stim_check #(
   parameter logic [31:0] SECRET = 32'd9,
   parameter logic [31:0] THRESH = 32'd10,
   parameter logic [31:0] A_MASK = 32'h0000_0003
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] num_vec,
   input  logic [31:0] seed,
   output logic [31:0] a,
   output logic [31:0] b,
   input  logic [31:0] x,
   output logic        busy,
   output logic        done,
   output logic [15:0] err_count,
   output logic [15:0] first_err_idx,
   output logic        pass
);

   localparam logic [31:0] c_lfsr_taps = 32'h8020_0003;
   localparam logic [15:0] c_no_err    = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_lfsr;
   logic [31:0] r_model_acc;
   logic [31:0] r_exp;
   logic        r_cmp_v;
   logic [15:0] r_cmp_idx;
   logic [15:0] r_num_vec;
   logic [15:0] r_vec_idx;

   logic        w_start_ok;
   logic        w_last_vec;
   logic        w_mismatch;
   logic [31:0] w_seed_nz;

   // Right-shifting Galois step, taps 32,22,2,1.
   function automatic logic [31:0] f_lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? c_lfsr_taps : 32'd0);
   endfunction

   function automatic logic [31:0] f_half_swap(input logic [31:0] v);
      return {v[15:0], v[31:16]};
   endfunction

   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last_vec = (r_vec_idx == (r_num_vec - 16'd1));
   assign w_mismatch = r_cmp_v && (x != r_exp);
   // An all-zero seed would lock the LFSR.
   assign w_seed_nz  = (seed == 32'd0) ? 32'd1 : seed;

   assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done = (r_state == S_DONE);
   assign pass = done && (err_count == 16'd0);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = (num_vec == 16'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last_vec) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Stimulus and model. Vector 0 is launched on the start edge so that
   // vector k sits on a/b during the k-th RUN cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a           <= 32'd0;
         b           <= 32'd0;
         r_lfsr      <= 32'd1;
         r_model_acc <= 32'd0;
         r_exp       <= 32'd0;
         r_cmp_v     <= 1'b0;
         r_cmp_idx   <= 16'd0;
         r_num_vec   <= 16'd0;
         r_vec_idx   <= 16'd0;
      end else begin
         // The model samples a/b on the same edge as the accumulator.
         r_model_acc <= r_model_acc + a;
         r_exp       <= (r_model_acc > THRESH) ? b : (a + b + SECRET);
         r_cmp_v     <= (r_state == S_RUN);
         r_cmp_idx   <= r_vec_idx;

         if (w_start_ok) begin
            r_num_vec <= num_vec;
            r_vec_idx <= 16'd0;
            if (num_vec != 16'd0) begin
               a      <= w_seed_nz & A_MASK;
               b      <= f_half_swap(w_seed_nz);
               r_lfsr <= f_lfsr_next(w_seed_nz);
            end else begin
               a      <= 32'd0;
               b      <= 32'd0;
               r_lfsr <= w_seed_nz;
            end
         end else if ((r_state == S_RUN) && !w_last_vec) begin
            a         <= r_lfsr & A_MASK;
            b         <= f_half_swap(r_lfsr);
            r_lfsr    <= f_lfsr_next(r_lfsr);
            r_vec_idx <= r_vec_idx + 16'd1;
         end else begin
            // Zero stimulus keeps the accumulator frozen between runs.
            a <= 32'd0;
            b <= 32'd0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Result bookkeeping
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count     <= 16'd0;
         first_err_idx <= c_no_err;
      end else if (w_start_ok) begin
         err_count     <= 16'd0;
         first_err_idx <= c_no_err;
      end else if (w_mismatch) begin
         if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
         end
         if (first_err_idx == c_no_err) begin
            first_err_idx <= r_cmp_idx;
         end
      end
   end

endmodule
`default_nettype wire
